pc_fetch_ctrl: RTL and testbench

- Sequences the program counter register (PC, 64-bit, reset vector 1023) and the instruction-memory fetch handshake.
- Decides each cycle whether the PC loads, and with what value: sequential increment or branch/jump redirect.
- Issues fetch requests to instruction memory and presents fetched-instruction validity to decode under a stall back-pressure.
- Sits between PC, instruction memory and the decode/branch-resolution stages.

---
 rtl/pc_ctrl_pkg.sv | 22 ++
 rtl/redirect_pending.sv | 47 ++++
 rtl/pc_fetch_ctrl.sv | 152 +++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_ctrl_pkg
// Shared definitions for the fetch controller, the PC register and the
// branch unit: the fetch FSM state encoding and the architectural constants
// (PC reset vector and sequential instruction step).
// ---------------------------------------------------------------------------
package pc_ctrl_pkg;

  // PC value after reset; the PC register must reset to the same value.
  localparam logic [63:0] RESET_VECTOR = 64'd1023;

  // Sequential PC increment in bytes.
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT,   // first cycle out of reset
    REQ,    // issue a fetch for pc_value
    WAIT,   // fetch outstanding, waiting for imem_ack
    VALID   // fetched instruction presented to decode
  } state_t;

endpackage

// File: rtl/redirect_pending.sv
// ---------------------------------------------------------------------------
// redirect_pending
// Remembers a branch/jump redirect that arrived while a fetch was still
// outstanding, so that the fetch can be discarded when it completes.
//
// Ports:
//   clk       clock
//   reset     synchronous active-high reset
//   set_i     record target_i as the pending redirect (latest one wins)
//   clr_i     drop the pending redirect (has priority over set_i)
//   target_i  redirect target to record
//   pend_o    a redirect is pending
//   target_o  pending redirect target
// ---------------------------------------------------------------------------
module redirect_pending #(
  parameter int unsigned BITS = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            set_i,
  input  logic            clr_i,
  input  logic [BITS-1:0] target_i,
  output logic            pend_o,
  output logic [BITS-1:0] target_o
);

  logic            pend_q;
  logic [BITS-1:0] target_q;

  // NOTE: state registers are written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q   <= 1'b0;
      target_q <= '0;
    end else if (clr_i) begin
      pend_q   <= 1'b0;
    end else if (set_i) begin
      pend_q   <= 1'b1;
      target_q <= target_i;
    end
  end

  assign pend_o   = pend_q;
  assign target_o = target_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
// Sequences the program counter and the instruction-memory fetch handshake.
// Each cycle it decides whether the external PC register loads (sequential
// step or branch/jump redirect), issues fetch requests, and presents the
// fetched instruction to decode under stall back-pressure.
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   reset            synchronous active-high reset
//   pc_value         current PC (PC register output)
//   pc_load          PC register load enable
//   pc_next          PC register input data (equals pc_value when not loading)
//   pc_reset         PC register reset, combinationally equal to reset
//   imem_req         fetch request, held until imem_ack
//   imem_addr        fetch address (pc_value)
//   imem_ack         fetch completion
//   stall            decode cannot accept this cycle
//   redirect         branch/jump taken (one-cycle pulse)
//   redirect_target  redirect destination, valid with redirect
//   instr_valid      instruction at pc_value is valid for decode
//   fetch_count      number of instructions accepted by decode (wraps)
// ---------------------------------------------------------------------------
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned BITS        = 64,
  parameter int unsigned INSTR_BYTES = pc_ctrl_pkg::INSTR_BYTES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] pc_value,
  output logic            pc_load,
  output logic [BITS-1:0] pc_next,
  output logic            pc_reset,
  output logic            imem_req,
  output logic [BITS-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic            stall,
  input  logic            redirect,
  input  logic [BITS-1:0] redirect_target,
  output logic            instr_valid,
  output logic [BITS-1:0] fetch_count
);

  state_t          state_q, state_d;
  logic [BITS-1:0] count_q, count_d;

  logic            pend;
  logic            pend_set;
  logic            pend_clr;
  logic [BITS-1:0] pend_target;

  redirect_pending #(
    .BITS (BITS)
  ) u_redirect_pending (
    .clk      (clk),
    .reset    (reset),
    .set_i    (pend_set),
    .clr_i    (pend_clr),
    .target_i (redirect_target),
    .pend_o   (pend),
    .target_o (pend_target)
  );

  // NOTE: every signal written here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pc_load     = 1'b0;
    pc_next     = pc_value;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    pend_set    = 1'b0;
    pend_clr    = 1'b0;

    // Reset outranks everything: outputs stay quiet and the flops reset.
    if (!reset) begin
      case (state_q)
        BOOT: begin
          state_d = REQ;
          if (redirect) begin
            pc_load = 1'b1;
            pc_next = redirect_target;
          end
        end

        REQ: begin
          if (redirect) begin
            // Retarget before requesting; the fetch goes out next cycle.
            pc_load = 1'b1;
            pc_next = redirect_target;
          end else begin
            imem_req = 1'b1;
            state_d  = WAIT;
          end
        end

        WAIT: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            pend_clr = 1'b1;
            if (redirect || pend) begin
              // The instruction just fetched is on the wrong path: drop it.
              pc_load = 1'b1;
              pc_next = redirect ? redirect_target : pend_target;
              state_d = REQ;
            end else begin
              state_d = VALID;
            end
          end else if (redirect) begin
            // PC must stay stable while the request is outstanding, so the
            // redirect is parked until the ack arrives.
            pend_set = 1'b1;
          end
        end

        VALID: begin
          instr_valid = !redirect;
          if (redirect) begin
            pc_load = 1'b1;
            pc_next = redirect_target;
            state_d = REQ;
          end else if (!stall) begin
            pc_load = 1'b1;
            pc_next = pc_value + BITS'(INSTR_BYTES);
            count_d = count_q + BITS'(1);
            state_d = REQ;
          end
        end

        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign pc_reset    = reset;
  assign imem_addr   = pc_value;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
// Self-checking bench for pc_fetch_ctrl. It provides the PC register and a
// memory that acks outstanding requests, keeps a transaction-level model of
// the fetch protocol, and compares every DUT output against that model on
// each falling edge. Directed sequences pin the model with literal values,
// then a randomized run exercises redirects, stalls, ack latency and reset.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

  localparam logic [63:0] RV = pc_ctrl_pkg::RESET_VECTOR;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic        imem_ack;
  logic [63:0] redirect_target;
  logic [63:0] pc_q;
  logic [63:0] pc_next;
  logic [63:0] imem_addr;
  logic [63:0] fetch_count;
  logic        pc_load;
  logic        pc_reset;
  logic        imem_req;
  logic        instr_valid;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(
    .BITS        (64),
    .INSTR_BYTES (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_value        (pc_q),
    .pc_load         (pc_load),
    .pc_next         (pc_next),
    .pc_reset        (pc_reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .fetch_count     (fetch_count)
  );

  // External PC register driven by the controller.
  always @(posedge clk) begin
    if (pc_reset)     pc_q <= RV;
    else if (pc_load) pc_q <= pc_next;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Outputs as seen by the compare process in the most recent cycle.
  logic        s_req, s_valid, s_load, s_reset;
  logic [63:0] s_addr, s_next;

  // Protocol model: what the fetch unit is doing, independent of RTL encoding.
  bit          m_known = 1'b0;  // model valid once a reset has been seen
  bit          m_boot, m_busy, m_have, m_pend;
  logic [63:0] m_tgt, m_cnt, m_pc;
  bit          n_known, n_boot, n_busy, n_have, n_pend;
  logic [63:0] n_tgt, n_cnt, n_pc;
  bit          e_load, e_req, e_valid;
  logic [63:0] e_next;

  initial begin : compare
    forever begin
      @(negedge clk);
      s_req   = imem_req;
      s_valid = instr_valid;
      s_load  = pc_load;
      s_reset = pc_reset;
      s_addr  = imem_addr;
      s_next  = pc_next;

      n_known = m_known; n_boot = m_boot; n_busy = m_busy; n_have = m_have;
      n_pend  = m_pend;  n_tgt  = m_tgt;  n_cnt  = m_cnt;  n_pc   = m_pc;

      check("pc_reset", pc_reset, reset);
      if (reset) begin
        check("rst_pc_load", pc_load, 1'b0);
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_pc_next", pc_next, pc_q);
        n_known = 1'b1; n_boot = 1'b1; n_busy = 1'b0; n_have = 1'b0;
        n_pend  = 1'b0; n_tgt  = '0;   n_cnt  = '0;   n_pc   = RV;
      end else if (m_known) begin
        e_load = 1'b0; e_next = m_pc; e_req = 1'b0; e_valid = 1'b0;
        if (m_boot) begin
          n_boot = 1'b0;
          if (redirect) begin e_load = 1'b1; e_next = redirect_target; end
        end else if (m_busy) begin
          e_req = 1'b1;
          if (imem_ack) begin
            n_busy = 1'b0;
            n_pend = 1'b0;
            if (redirect || m_pend) begin
              e_load = 1'b1;
              e_next = redirect ? redirect_target : m_tgt;
            end else begin
              n_have = 1'b1;
            end
          end else if (redirect) begin
            n_pend = 1'b1;
            n_tgt  = redirect_target;
          end
        end else if (m_have) begin
          e_valid = !redirect;
          if (redirect) begin
            e_load = 1'b1; e_next = redirect_target; n_have = 1'b0;
          end else if (!stall) begin
            e_load = 1'b1; e_next = m_pc + 64'd4; n_cnt = m_cnt + 64'd1; n_have = 1'b0;
          end
        end else begin
          if (redirect) begin e_load = 1'b1; e_next = redirect_target; end
          else begin e_req = 1'b1; n_busy = 1'b1; end
        end
        if (e_load) n_pc = e_next;

        check("pc_value", pc_q, m_pc);
        check("pc_load", pc_load, e_load);
        check("pc_next", pc_next, e_next);
        check("imem_req", imem_req, e_req);
        if (e_req) check("imem_addr", imem_addr, m_pc);
        check("instr_valid", instr_valid, e_valid);
        check("fetch_count", fetch_count, m_cnt);
      end

      @(posedge clk);
      m_known = n_known; m_boot = n_boot; m_busy = n_busy; m_have = n_have;
      m_pend  = n_pend;  m_tgt  = n_tgt;  m_cnt  = n_cnt;  m_pc   = n_pc;
    end
  end

  // Memory side: a request seen last cycle and not yet acked is outstanding.
  bit mem_busy = 1'b0;
  bit req_seen;

  task automatic cyc(input bit r, input bit s, input bit rd, input logic [63:0] t, input bit a);
    reset = r; stall = s; redirect = rd; redirect_target = t; imem_ack = a;
    @(negedge clk);
    req_seen = imem_req;
    @(posedge clk);
    #1;
    mem_busy = !r && req_seen && !a;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  bit          r_r, r_s, r_rd, r_a;
  logic [63:0] r_t;

  initial begin : stim
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0; imem_ack = 1'b0;

    // Reset, then three back-to-back fetches with a 1-cycle ack.
    cyc(1, 0, 0, 0, 0);
    check("lit_rst_pc_reset", s_reset, 1'b1);
    check("lit_rst_req", s_req, 1'b0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("lit_boot_count", fetch_count, 64'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 0);
      check("lit_seq_addr", s_addr, RV + 64'(4 * k));
      check("lit_seq_req", s_req, 1'b1);
      check("lit_seq_valid_req", s_valid, 1'b0);
      cyc(0, 0, 0, 0, 1);
      check("lit_seq_valid_wait", s_valid, 1'b0);
      cyc(0, 0, 0, 0, 0);
      check("lit_seq_valid", s_valid, 1'b1);
      check("lit_seq_next", s_next, RV + 64'(4 * (k + 1)));
    end
    check("lit_seq_count3", fetch_count, 64'd3);

    // Stall for 4 cycles in VALID at pc 1027.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("lit_stall_addr", s_addr, 64'd1027);
    cyc(0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 0, 0, 0);
      check("lit_stall_valid", s_valid, 1'b1);
      check("lit_stall_load", s_load, 1'b0);
      check("lit_stall_count", fetch_count, 64'd1);
    end
    cyc(0, 0, 0, 0, 0);
    check("lit_unstall_load", s_load, 1'b1);
    check("lit_unstall_next", s_next, 64'd1031);
    check("lit_unstall_count", fetch_count, 64'd2);

    // Redirect parked during WAIT, ack 3 cycles later.
    cyc(0, 0, 0, 0, 0);
    check("lit_wait_addr", s_addr, 64'd1031);
    cyc(0, 0, 1, 64'h2000, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("lit_pend_load", s_load, 1'b1);
    check("lit_pend_next", s_next, 64'h2000);
    check("lit_pend_valid", s_valid, 1'b0);
    cyc(0, 0, 0, 0, 0);
    check("lit_pend_addr", s_addr, 64'h2000);

    // Two redirects before the ack: the later one wins.
    cyc(0, 0, 1, 64'h2000, 0);
    cyc(0, 0, 1, 64'h3000, 0);
    cyc(0, 0, 0, 0, 1);
    check("lit_pend2_next", s_next, 64'h3000);
    cyc(0, 0, 0, 0, 0);
    check("lit_pend2_addr", s_addr, 64'h3000);

    // Redirect and ack in the same WAIT cycle.
    cyc(0, 0, 1, 64'h400, 1);
    check("lit_same_load", s_load, 1'b1);
    check("lit_same_next", s_next, 64'h400);
    check("lit_same_valid", s_valid, 1'b0);
    cyc(0, 0, 0, 0, 0);
    check("lit_same_addr", s_addr, 64'h400);
    cyc(0, 0, 0, 0, 1);

    // Redirect in VALID beats stall.
    cyc(0, 1, 1, 64'h500, 0);
    check("lit_vred_valid", s_valid, 1'b0);
    check("lit_vred_next", s_next, 64'h500);
    check("lit_vred_count", fetch_count, 64'd2);

    // Redirect in REQ to 2^64-4, then accept: PC wraps to 0.
    cyc(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    check("lit_rred_req", s_req, 1'b0);
    check("lit_rred_load", s_load, 1'b1);
    cyc(0, 0, 0, 0, 0);
    check("lit_wrap_addr", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    check("lit_wrap_next", s_next, 64'd0);
    check("lit_wrap_count", fetch_count, 64'd3);

    // Reset while waiting, late ack in BOOT must be ignored.
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("lit_midrst_req", s_req, 1'b0);
    cyc(0, 0, 0, 0, 1);
    check("lit_late_ack_valid", s_valid, 1'b0);
    check("lit_late_ack_load", s_load, 1'b0);
    check("lit_late_ack_pc", pc_q, RV);
    cyc(0, 0, 0, 0, 0);
    check("lit_after_rst_addr", s_addr, RV);
    check("lit_after_rst_req", s_req, 1'b1);

    // Redirect in BOOT.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 64'h1234, 0);
    check("lit_boot_red_load", s_load, 1'b1);
    check("lit_boot_red_next", s_next, 64'h1234);
    cyc(0, 0, 0, 0, 0);
    check("lit_boot_red_addr", s_addr, 64'h1234);

    // Randomized traffic checked cycle by cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      r_r  = ($urandom_range(0, 249) == 0);
      r_s  = ($urandom_range(0, 2) == 0);
      r_rd = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) r_t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else                           r_t = {$urandom(), $urandom()};
      r_a  = mem_busy && ($urandom_range(0, 2) != 0);
      cyc(r_r, r_s, r_rd, r_t, r_a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
